// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   Wait-state data memory responder for a simple core bus. It accepts one
//   request at a time, waits WAIT_CYCLES extra cycles, then performs the
//   load or store. The response is held until the core takes it.
//
// Parameters:
//   DEPTH        number of 32-bit words in the storage array (default 64)
//   WAIT_CYCLES  extra wait states per access, 0..15 (default 2)
//
// Configuration macro:
//   DMEM_BYTE_STROBE_EN  when defined, a store writes only the bytes whose
//                        req_wstrb bit is set. When undefined, req_wstrb is
//                        ignored and every legal store writes the full word.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous reset, active low
//   req_valid  in   1   core presents a request
//   req_ready  out  1   block accepts a request this cycle (IDLE only)
//   req_write  in   1   1 = store, 0 = load
//   req_addr   in   32  byte address (word index = addr[31:2])
//   req_wdata  in   32  store data
//   req_wstrb  in   4   byte enables, bit i covers wdata[8i+7:8i]
//   rsp_valid  out  1   response presented
//   rsp_ready  in   1   core accepts the response
//   rsp_rdata  out  32  load data, 0 for stores and errors
//   rsp_err    out  1   access was misaligned or out of range
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem_q [DEPTH];

  // Address decode works on the latched request so that bus activity after
  // acceptance cannot influence the access.
  logic [29:0]      word_idx;
  logic             access_err;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      store_word_d;

  assign word_idx   = addr_q[31:2];
  assign access_err = (addr_q[1:0] != 2'b00) || ({2'b00, word_idx} >= 32'(DEPTH));
  assign mem_idx    = word_idx[IDX_W-1:0];

`ifdef DMEM_BYTE_STROBE_EN
  // Merge enabled bytes of the store data into the current word; a zero
  // strobe rewrites the word unchanged.
  always_comb begin
    store_word_d = mem_q[mem_idx];
    for (int b = 0; b < 4; b++) begin
      if (wstrb_q[b]) begin
        store_word_d[8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
  end
`else
  // Strobes are latched for uniformity but do not affect the write.
  logic unused_wstrb;
  assign unused_wstrb = ^wstrb_q;
  assign store_word_d = wdata_q;
`endif

  // Single FSM: IDLE accepts, WAIT counts down then performs the access on
  // the edge where the counter is zero, RESP holds the result until taken.
  // Memory shares the asynchronous reset so that reset clears every word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            wstrb_q     <= req_wstrb;
            cnt_q       <= 4'(WAIT_CYCLES);
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end

        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            if (access_err) begin
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'd0;
            end else begin
              rsp_err_q <= 1'b0;
              if (write_q) begin
                mem_q[mem_idx] <= store_word_d;
                rsp_rdata_q    <= 32'd0;
              end else begin
                rsp_rdata_q <= mem_q[mem_idx];
              end
            end
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= 32'd0;
          rsp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Scoreboard bench for dmem_responder. One instance uses WAIT_CYCLES=2 for
// latency, backpressure, error, strobe and reset tests; a second instance
// uses WAIT_CYCLES=0 for the back-to-back throughput test. Expected results
// come from a small reference memory model in the bench.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int WAIT_CYC = 2;
  localparam int DEPTH    = 64;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } expT;

  logic        clk = 1'b0;
  logic        reset;

  logic        reqValid, reqReady, reqWrite;
  logic [31:0] reqAddr, reqWdata;
  logic [3:0]  reqWstrb;
  logic        rspValid, rspReady, rspErr;
  logic [31:0] rspRdata;

  logic        zReqValid, zReqReady, zReqWrite;
  logic [31:0] zReqAddr, zReqWdata;
  logic [3:0]  zReqWstrb;
  logic        zRspValid, zRspReady, zRspErr;
  logic [31:0] zRspRdata;

  logic [31:0] modelMem  [DEPTH];
  logic [31:0] zModelMem [DEPTH];
  expT         expQ[$];
  expT         zExpQ[$];

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(reqValid), .req_ready(reqReady), .req_write(reqWrite),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_wstrb(reqWstrb),
    .rsp_valid(rspValid), .rsp_ready(rspReady),
    .rsp_rdata(rspRdata), .rsp_err(rspErr)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dutZero (
    .clk(clk), .reset(reset),
    .req_valid(zReqValid), .req_ready(zReqReady), .req_write(zReqWrite),
    .req_addr(zReqAddr), .req_wdata(zReqWdata), .req_wstrb(zReqWstrb),
    .rsp_valid(zRspValid), .rsp_ready(zRspReady),
    .rsp_rdata(zRspRdata), .rsp_err(zRspErr)
  );

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference memory: computes the expected response and applies stores.
  task automatic modelAccess(input bit zeroSide, input logic w, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb, output expT e);
    logic [31:0] word;
    int          idx;
    e.err   = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
    e.rdata = 32'd0;
    idx     = int'(addr[7:2]);
    if (!e.err) begin
      word = zeroSide ? zModelMem[idx] : modelMem[idx];
      if (w) begin
`ifdef DMEM_BYTE_STROBE_EN
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) word[8*b +: 8] = wdata[8*b +: 8];
        end
`else
        word = wdata;
`endif
        if (zeroSide) zModelMem[idx] = word;
        else modelMem[idx] = word;
      end else begin
        e.rdata = word;
      end
    end
  endtask

  task automatic clearModels();
    for (int i = 0; i < DEPTH; i++) begin
      modelMem[i]  = 32'd0;
      zModelMem[i] = 32'd0;
    end
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance. Request fields are
  // scrambled (with valid still high) after acceptance to prove they are
  // ignored; the response is held for 'stall' cycles before being taken.
  task automatic applyStimulus(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input int stall);
    expT e;
    expT got;
    int  lat;
    @(negedge clk);
    checkOutput("req_ready_idle", reqReady, 1);
    reqValid = 1'b1;
    reqWrite = w;
    reqAddr  = addr;
    reqWdata = wdata;
    reqWstrb = wstrb;
    @(posedge clk);
    modelAccess(1'b0, w, addr, wdata, wstrb, e);
    expQ.push_back(e);
    @(negedge clk);
    reqWrite = 1'b1;
    reqAddr  = $urandom & 32'h0000_00FC;
    reqWdata = $urandom;
    reqWstrb = 4'hF;
    lat = 0;
    while (!rspValid && lat < 40) begin
      checkOutput("req_ready_wait", reqReady, 0);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    got = expQ.pop_front();
    if (!rspValid) begin
      checkOutput("rsp_timeout", 0, 1);
      reqValid = 1'b0;
      return;
    end
    checkOutput("latency", lat, WAIT_CYC + 1);
    for (int s = 0; s < stall; s++) begin
      checkOutput("stall_valid", rspValid, 1);
      checkOutput("stall_rdata", rspRdata, got.rdata);
      checkOutput("stall_err", rspErr, got.err);
      checkOutput("stall_req_ready", reqReady, 0);
      @(posedge clk);
      @(negedge clk);
      reqAddr  = $urandom & 32'h0000_00FC;
      reqWdata = $urandom;
    end
    checkOutput("rsp_valid", rspValid, 1);
    checkOutput("rsp_rdata", rspRdata, got.rdata);
    checkOutput("rsp_err", rspErr, got.err);
    reqValid  = 1'b0;
    rspReady  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rspReady = 1'b0;
    checkOutput("clr_valid", rspValid, 0);
    checkOutput("clr_rdata", rspRdata, 0);
    checkOutput("clr_err", rspErr, 0);
    checkOutput("clr_req_ready", reqReady, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        tW   [4];
    logic [31:0] tAddr[4];
    logic [31:0] tData[4];
    expT         e;
    expT         got;

    reset     = 1'b0;
    reqValid  = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWdata = '0; reqWstrb = '0;
    rspReady  = 1'b0;
    zReqValid = 1'b0; zReqWrite = 1'b0; zReqAddr = '0; zReqWdata = '0; zReqWstrb = 4'hF;
    zRspReady = 1'b1;
    clearModels();

    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", reqReady, 1);
    checkOutput("rst_rsp_valid", rspValid, 0);
    checkOutput("rst_rsp_rdata", rspRdata, 0);
    checkOutput("rst_rsp_err", rspErr, 0);
    reset = 1'b1;

    // Latency, then read-back under backpressure
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, 5);

    // Misaligned load, out-of-range store, memory untouched
    applyStimulus(1'b0, 32'h12, 32'h0, 4'hF, 0);
    applyStimulus(1'b1, 32'h100, 32'h12345678, 4'hF, 1);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, 0);

    // Byte strobes and an all-zero strobe
    applyStimulus(1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    applyStimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, 0);
    applyStimulus(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, 2);

    // Highest legal word
    applyStimulus(1'b1, 32'hFC, 32'h0BADF00D, 4'hF, 0);
    applyStimulus(1'b0, 32'hFC, 32'h0, 4'hF, 0);

    // Committed word at 0x4 that reset must clear
    applyStimulus(1'b1, 32'h4, 32'h00000077, 4'hF, 0);
    applyStimulus(1'b0, 32'h4, 32'h0, 4'hF, 0);

    // Reset during WAIT aborts the pending store
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h4; reqWdata = 32'h55; reqWstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    reset = 1'b0;
    clearModels();
    #1;
    checkOutput("midwait_rst_req_ready", reqReady, 1);
    checkOutput("midwait_rst_rsp_valid", rspValid, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      checkOutput("post_rst_rsp_valid", rspValid, 0);
      checkOutput("post_rst_req_ready", reqReady, 1);
      @(negedge clk);
    end
    applyStimulus(1'b0, 32'h4, 32'h0, 4'hF, 0);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, 0);

    // Zero wait states, request held continuously, response always taken
    tW[0] = 1'b1; tAddr[0] = 32'h8;   tData[0] = 32'hCAFEF00D;
    tW[1] = 1'b0; tAddr[1] = 32'h8;   tData[1] = 32'h0;
    tW[2] = 1'b1; tAddr[2] = 32'h104; tData[2] = 32'h13572468;
    tW[3] = 1'b0; tAddr[3] = 32'h8;   tData[3] = 32'h0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      checkOutput("zero_req_ready", zReqReady, (n % 3 == 0) ? 1 : 0);
      checkOutput("zero_rsp_valid", zRspValid, (n % 3 == 2) ? 1 : 0);
      if (n % 3 == 2) begin
        if (zExpQ.size() == 0) begin
          checkOutput("zero_queue_empty", 0, 1);
        end else begin
          got = zExpQ.pop_front();
          checkOutput("zero_rsp_rdata", zRspRdata, got.rdata);
          checkOutput("zero_rsp_err", zRspErr, got.err);
        end
      end
      if (n % 3 == 0) begin
        zReqValid = 1'b1;
        zReqWrite = tW[n/3];
        zReqAddr  = tAddr[n/3];
        zReqWdata = tData[n/3];
        modelAccess(1'b1, tW[n/3], tAddr[n/3], tData[n/3], 4'hF, e);
        zExpQ.push_back(e);
      end else begin
        zReqWrite = 1'b1;
        zReqAddr  = 32'h8;
        zReqWdata = $urandom;
      end
    end
    zReqValid = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
